// File: rtl/has_down_counter_hs_cell.sv
// One half-subtractor bit: subtracts the incoming borrow from the stored bit.
// Chained LSB-to-MSB to form the decrement path of has_down_counter.
module hs_cell (
  input  logic q_i,
  input  logic b_i,
  output logic d_o,
  output logic b_o
);

  assign d_o = q_i ^ b_i;
  assign b_o = ~q_i & b_i;

endmodule

// File: rtl/has_down_counter.sv
// Loadable N-bit down-counter built from a ripple chain of half-subtractor cells,
// with a captured reload value, optional auto-reload, zero flag and terminal-count pulse.
module has_down_counter #(
  parameter int N = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         Load,
  input  logic [N-1:0] In,
  input  logic         En,
  input  logic         AutoRld,
  output logic [N-1:0] Out,
  output logic         Bout,
  output logic         Zero,
  output logic         Done
);

  logic [N-1:0] out_q, out_d;
  logic [N-1:0] rel_q, rel_d;
  logic         done_q, done_d;
  logic [N:0]   borrow;
  logic [N-1:0] chain;

  assign borrow[0] = En;

  // With En low every borrow is 0, so the chain output equals the current value.
  for (genvar i = 0; i < N; i++) begin : g_cell
    hs_cell u_cell (
      .q_i (out_q[i]),
      .b_i (borrow[i]),
      .d_o (chain[i]),
      .b_o (borrow[i+1])
    );
  end

  assign Bout = borrow[N];
  assign Zero = (out_q == '0);
  assign Out  = out_q;
  assign Done = done_q;

  always_comb begin
    out_d  = chain;
    rel_d  = rel_q;
    done_d = 1'b0;
    if (Load) begin
      out_d = In;
      rel_d = In;
    end else if (Bout) begin
      // Underflow: chain already produced all-ones; auto-reload overrides it.
      if (AutoRld) out_d = rel_q;
    end else if (En) begin
      done_d = (out_q == N'(1));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q  <= '0;
      rel_q  <= '0;
      done_q <= 1'b0;
    end else begin
      out_q  <= out_d;
      rel_q  <= rel_d;
      done_q <= done_d;
    end
  end

endmodule

// File: tb/tb_has_down_counter.sv
// Self-checking bench for has_down_counter: directed scenarios plus randomized
// traffic compared against a behavioural countdown model.
module tb_has_down_counter;

  localparam int N = 10;
  localparam int MAXV = (1 << N) - 1;

  logic         clk;
  logic         rst;
  logic         Load;
  logic [N-1:0] In;
  logic         En;
  logic         AutoRld;
  logic [N-1:0] Out;
  logic         Bout;
  logic         Zero;
  logic         Done;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  int mOut;
  int mRel;
  int mDone;

  has_down_counter #(.N(N)) dut (
    .clk     (clk),
    .rst     (rst),
    .Load    (Load),
    .In      (In),
    .En      (En),
    .AutoRld (AutoRld),
    .Out     (Out),
    .Bout    (Bout),
    .Zero    (Zero),
    .Done    (Done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic ld, input int val, input logic en, input logic ar);
    Load    = ld;
    In      = val[N-1:0];
    En      = en;
    AutoRld = ar;
  endtask

  // Advance one clock, evolving the model from the inputs seen at the edge.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      mOut = 0; mRel = 0; mDone = 0;
    end else if (Load) begin
      mOut = int'(In); mRel = int'(In); mDone = 0;
    end else if (En) begin
      if (mOut != 0) begin
        mDone = (mOut == 1) ? 1 : 0;
        mOut  = mOut - 1;
      end else begin
        mOut  = AutoRld ? mRel : MAXV;
        mDone = 0;
      end
    end else begin
      mDone = 0;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    applyStimulus(1'b0, 0, 1'b0, 1'b0);
    mOut = 0; mRel = 0; mDone = 0;
    #12;
    rst = 1'b0;
    @(negedge clk);
    applyStimulus(1'b1, 'h155, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 0, 1'b0, 1'b0);
    if (Out !== 10'h155) begin
      errors++; $display("[TB] FAIL reset_preload: Out=%h expected 155", Out);
    end
    checks++;
    #2;
    rst = 1'b1;
    #1;
    mOut = 0; mRel = 0; mDone = 0;
    if (Out !== 10'h000 || Zero !== 1'b1 || Done !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_async: Out=%h Zero=%b Done=%b expected 000 1 0", Out, Zero, Done);
    end
    checks++;
    En = 1'b1; #1;
    if (Bout !== 1'b1) begin
      errors++; $display("[TB] FAIL reset_bout_en1: Bout=%b expected 1", Bout);
    end
    checks++;
    En = 1'b0; #1;
    if (Bout !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_bout_en0: Bout=%b expected 0", Bout);
    end
    checks++;
    @(negedge clk);
    rst = 1'b0;
    // Reload register must have been cleared: auto-reload from 0 stays at 0.
    applyStimulus(1'b0, 0, 1'b1, 1'b1);
    tick();
    if (Out !== 10'h000 || Done !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_relval: Out=%h Done=%b expected 000 0", Out, Done);
    end
    checks++;
  endtask

  task automatic test_load_count();
    int expSeq[5] = '{4, 3, 2, 1, 0};
    applyStimulus(1'b1, 5, 1'b0, 1'b0);
    tick();
    if (Out !== 10'd5 || Done !== 1'b0) begin
      errors++; $display("[TB] FAIL load5: Out=%0d Done=%b expected 5 0", Out, Done);
    end
    checks++;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 0, 1'b1, 1'b0);
      tick();
      if (Out !== expSeq[i][N-1:0] || Done !== (expSeq[i] == 0) || Zero !== (expSeq[i] == 0)) begin
        errors++;
        $display("[TB] FAIL count_step%0d: Out=%0d Done=%b Zero=%b expected %0d %b %b",
                 i, Out, Done, Zero, expSeq[i], expSeq[i] == 0, expSeq[i] == 0);
      end
      checks++;
    end
  endtask

  task automatic test_wrap();
    applyStimulus(1'b0, 0, 1'b1, 1'b0);
    #1;
    if (Bout !== 1'b1) begin
      errors++; $display("[TB] FAIL wrap_bout: Bout=%b expected 1", Bout);
    end
    checks++;
    tick();
    if (Out !== 10'h3FF || Done !== 1'b0) begin
      errors++; $display("[TB] FAIL wrap_out: Out=%h Done=%b expected 3ff 0", Out, Done);
    end
    checks++;
  endtask

  task automatic test_autoreload();
    int expSeq[9] = '{2, 1, 0, 3, 2, 1, 0, 3, 2};
    applyStimulus(1'b1, 3, 1'b0, 1'b1);
    tick();
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1'b0, 0, 1'b1, 1'b1);
      #1;
      if (Bout !== (Out == 0)) begin
        errors++; $display("[TB] FAIL autorld_bout%0d: Bout=%b Out=%0d", i, Bout, Out);
      end
      checks++;
      tick();
      if (Out !== expSeq[i][N-1:0] || Done !== (expSeq[i] == 0)) begin
        errors++;
        $display("[TB] FAIL autorld_step%0d: Out=%0d Done=%b expected %0d %b",
                 i, Out, Done, expSeq[i], expSeq[i] == 0);
      end
      checks++;
    end
  endtask

  task automatic test_priority();
    applyStimulus(1'b1, 7, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 'h200, 1'b1, 1'b0);
    tick();
    if (Out !== 10'h200) begin
      errors++; $display("[TB] FAIL prio_load: Out=%h expected 200", Out);
    end
    checks++;
    applyStimulus(1'b0, 0, 1'b0, 1'b0);
    tick();
    if (Out !== 10'h200 || Bout !== 1'b0) begin
      errors++; $display("[TB] FAIL prio_hold: Out=%h Bout=%b expected 200 0", Out, Bout);
    end
    checks++;
  endtask

  task automatic test_borrow();
    applyStimulus(1'b0, 0, 1'b1, 1'b0);
    #1;
    if (Bout !== 1'b0) begin
      errors++; $display("[TB] FAIL ripple_bout: Bout=%b expected 0", Bout);
    end
    checks++;
    tick();
    if (Out !== 10'h1FF) begin
      errors++; $display("[TB] FAIL ripple_out: Out=%h expected 1ff", Out);
    end
    checks++;
    applyStimulus(1'b1, 0, 1'b0, 1'b0);
    tick();
    if (Zero !== 1'b1 || Done !== 1'b0) begin
      errors++; $display("[TB] FAIL load0: Zero=%b Done=%b expected 1 0", Zero, Done);
    end
    checks++;
    applyStimulus(1'b0, 0, 1'b0, 1'b0);
    tick();
    if (Done !== 1'b0) begin
      errors++; $display("[TB] FAIL load0_hold: Done=%b expected 0", Done);
    end
    checks++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      logic ld;
      int   val;
      ld  = ($urandom_range(0, 15) == 0);
      val = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, MAXV));
      applyStimulus(ld, val, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
      #1;
      if (Bout !== (En && mOut == 0)) begin
        errors++; $display("[TB] FAIL rand_bout%0d: Bout=%b expected %b", i, Bout, En && mOut == 0);
      end
      checks++;
      tick();
      if (Out !== mOut[N-1:0] || Done !== mDone[0] || Zero !== (mOut == 0)) begin
        errors++;
        $display("[TB] FAIL rand_state%0d: Out=%h Done=%b Zero=%b expected %h %b %b",
                 i, Out, Done, Zero, mOut[N-1:0], mDone[0], mOut == 0);
      end
      checks++;
    end
  endtask

  initial begin
    test_reset();
    test_load_count();
    test_wrap();
    test_autoreload();
    test_priority();
    test_borrow();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
